// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch run-control sequencer with seconds prescaler
module stopwatch_ctrl #(
  parameter int TICK_DIV    = 100000000,
  parameter int PS_W        = 27,
  parameter int SEC_MAX     = 59,
  parameter int MIN_MAX     = 99,
  parameter int STOP_AT_MAX = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic [5:0] sec_count,
  input  logic [7:0] min_count,
  output logic       sec_en,
  output logic       min_en,
  output logic       cnt_clear,
  output logic       running,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  state_t          r_state;
  logic [PS_W-1:0] r_ps;
  logic            r_sec_en;
  logic            r_cnt_clear;
  logic            r_running;

  state_t          w_next_state;
  logic [PS_W-1:0] w_next_ps;
  logic            w_next_sec_en;
  logic            w_next_cnt_clear;
  logic            w_wrap;
  logic            w_terminal;

  // A wrap is only meaningful while running; a terminal wrap parks the watch in DONE.
  always_comb begin
    w_wrap     = (r_state == ST_RUN) && (r_ps == PS_LAST);
    w_terminal = w_wrap && (sec_count == 6'(SEC_MAX)) &&
                 (min_count == 8'(MIN_MAX)) && (STOP_AT_MAX != 0);
  end

  // Next-state, prescaler and registered-pulse decode; clear beats stop beats start.
  always_comb begin
    w_next_state     = r_state;
    w_next_ps        = r_ps;
    w_next_sec_en    = 1'b0;
    w_next_cnt_clear = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (clear) begin
          w_next_cnt_clear = 1'b1;
          w_next_ps        = '0;
        end else if (stop) begin
          w_next_state = ST_IDLE;
        end else if (start) begin
          w_next_state = ST_RUN;
          w_next_ps    = '0;
        end
      end
      ST_RUN: begin
        if (clear) begin
          w_next_state     = ST_IDLE;
          w_next_ps        = '0;
          w_next_cnt_clear = 1'b1;
        end else if (stop) begin
          // Prescaler holds so a resume finishes the partial second.
          w_next_state = ST_PAUSE;
        end else if (w_wrap) begin
          w_next_ps = '0;
          if (w_terminal) begin
            w_next_state = ST_DONE;
          end else begin
            w_next_sec_en = 1'b1;
          end
        end else begin
          w_next_ps = r_ps + 1'b1;
        end
      end
      ST_PAUSE: begin
        if (clear) begin
          w_next_state     = ST_IDLE;
          w_next_ps        = '0;
          w_next_cnt_clear = 1'b1;
        end else if (stop) begin
          w_next_state = ST_PAUSE;
        end else if (start) begin
          w_next_state = ST_RUN;
        end
      end
      ST_DONE: begin
        if (clear) begin
          w_next_state     = ST_IDLE;
          w_next_ps        = '0;
          w_next_cnt_clear = 1'b1;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_ps    = '0;
      end
    endcase
  end

  // State, prescaler and registered output pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ps        <= '0;
      r_sec_en    <= 1'b0;
      r_cnt_clear <= 1'b0;
      r_running   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_ps        <= w_next_ps;
      r_sec_en    <= w_next_sec_en;
      r_cnt_clear <= w_next_cnt_clear;
      r_running   <= (w_next_state == ST_RUN);
    end
  end

  // Minutes advance on the same edge the seconds counter rolls over.
  always_comb begin
    sec_en    = r_sec_en;
    min_en    = r_sec_en && (sec_count == 6'(SEC_MAX));
    cnt_clear = r_cnt_clear;
    running   = r_running;
    state     = r_state;
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed self-checking bench for stopwatch_ctrl
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic [5:0] sec_count = 6'd0;
  logic [7:0] min_count = 8'd0;

  logic       sec_en_a, min_en_a, cnt_clear_a, running_a;
  logic [1:0] state_a;
  logic       sec_en_b, min_en_b, cnt_clear_b, running_b;
  logic [1:0] state_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .TICK_DIV(4), .PS_W(3), .SEC_MAX(59), .MIN_MAX(99), .STOP_AT_MAX(1)
  ) u_halt (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .sec_count(sec_count), .min_count(min_count),
    .sec_en(sec_en_a), .min_en(min_en_a), .cnt_clear(cnt_clear_a),
    .running(running_a), .state(state_a)
  );

  stopwatch_ctrl #(
    .TICK_DIV(4), .PS_W(3), .SEC_MAX(59), .MIN_MAX(99), .STOP_AT_MAX(0)
  ) u_roll (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .sec_count(sec_count), .min_count(min_count),
    .sec_en(sec_en_b), .min_en(min_en_b), .cnt_clear(cnt_clear_b),
    .running(running_b), .state(state_b)
  );

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int first_pulse;
    int n_pulses;
    int last_pulse;
    int bad_gap;
    int not_running;
    int paused_pulses;

    // Reset held two cycles with start asserted
    rst = 1'b1;
    start = 1'b1;
    tick();
    tick();
    expect_eq("rst_state", 32'(state_a), 32'd0);
    expect_eq("rst_sec_en", 32'(sec_en_a), 32'd0);
    expect_eq("rst_min_en", 32'(min_en_a), 32'd0);
    expect_eq("rst_cnt_clear", 32'(cnt_clear_a), 32'd0);
    expect_eq("rst_running", 32'(running_a), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    tick();
    expect_eq("idle_state", 32'(state_a), 32'd0);

    // Start and run 12 cycles
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_eq("start_state", 32'(state_a), 32'd1);
    expect_eq("start_running", 32'(running_a), 32'd1);
    first_pulse = -1;
    n_pulses = 0;
    last_pulse = 0;
    bad_gap = 0;
    not_running = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (running_a !== 1'b1) not_running++;
      if (sec_en_a === 1'b1) begin
        if (first_pulse < 0) first_pulse = i;
        else if (i - last_pulse != 4) bad_gap++;
        last_pulse = i;
        n_pulses++;
      end
    end
    expect_eq("run_pulse_count", 32'(n_pulses), 32'd3);
    expect_eq("run_first_pulse", 32'(first_pulse), 32'd4);
    expect_eq("run_pulse_gap", 32'(bad_gap), 32'd0);
    expect_eq("run_running", 32'(not_running), 32'd0);

    // Pause with prescaler at 2, resume later
    tick();
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    expect_eq("pause_state", 32'(state_a), 32'd2);
    expect_eq("pause_running", 32'(running_a), 32'd0);
    paused_pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sec_en_a === 1'b1) paused_pulses++;
    end
    expect_eq("pause_no_tick", 32'(paused_pulses), 32'd0);
    sec_count = 6'd58;
    min_count = 8'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_eq("resume_state", 32'(state_a), 32'd1);
    expect_eq("resume_sec_en0", 32'(sec_en_a), 32'd0);
    tick();
    expect_eq("resume_sec_en1", 32'(sec_en_a), 32'd0);
    tick();
    expect_eq("resume_sec_en2", 32'(sec_en_a), 32'd1);
    expect_eq("no_overflow_min_en", 32'(min_en_a), 32'd0);

    // Seconds overflow into minutes
    sec_count = 6'd59;
    for (int i = 0; i < 3; i++) tick();
    expect_eq("ovf_pre_sec_en", 32'(sec_en_a), 32'd0);
    tick();
    expect_eq("ovf_sec_en", 32'(sec_en_a), 32'd1);
    expect_eq("ovf_min_en", 32'(min_en_a), 32'd1);

    // Terminal wrap at 99:59
    min_count = 8'd99;
    for (int i = 0; i < 3; i++) tick();
    tick();
    expect_eq("term_halt_state", 32'(state_a), 32'd3);
    expect_eq("term_halt_sec_en", 32'(sec_en_a), 32'd0);
    expect_eq("term_halt_min_en", 32'(min_en_a), 32'd0);
    expect_eq("term_halt_running", 32'(running_a), 32'd0);
    expect_eq("term_roll_state", 32'(state_b), 32'd1);
    expect_eq("term_roll_sec_en", 32'(sec_en_b), 32'd1);
    expect_eq("term_roll_min_en", 32'(min_en_b), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_eq("done_ignore_start", 32'(state_a), 32'd3);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    expect_eq("done_ignore_stop", 32'(state_a), 32'd3);
    expect_eq("done_no_sec_en", 32'(sec_en_a), 32'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    expect_eq("done_clear_pulse", 32'(cnt_clear_a), 32'd1);
    expect_eq("done_clear_state", 32'(state_a), 32'd0);
    tick();
    expect_eq("done_clear_once", 32'(cnt_clear_a), 32'd0);
    expect_eq("done_idle_state", 32'(state_a), 32'd0);

    // All commands in RUN coinciding with a wrap
    sec_count = 6'd0;
    min_count = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    clear = 1'b1;
    stop = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    stop = 1'b0;
    start = 1'b0;
    expect_eq("simul_cnt_clear", 32'(cnt_clear_a), 32'd1);
    expect_eq("simul_sec_en", 32'(sec_en_a), 32'd0);
    expect_eq("simul_state", 32'(state_a), 32'd0);

    // stop+start together in PAUSE
    start = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b1;
    tick();
    expect_eq("pause_again", 32'(state_a), 32'd2);
    start = 1'b1;
    tick();
    stop = 1'b0;
    start = 1'b0;
    expect_eq("pause_stop_start", 32'(state_a), 32'd2);

    // Reset overrides a coincident start
    start = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    expect_eq("rst_override_state", 32'(state_a), 32'd0);
    expect_eq("rst_override_running", 32'(running_a), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
